// File: rtl/stream_demux.sv
// 1-to-2 valid/ready stream demux: in_sel steers each beat into a per-destination FIFO.
// Latency 1 cycle from input transfer to outk_valid (no empty-FIFO bypass).
// in_ready = !full[in_sel] from registered occupancy only; a stalled sink blocks only its own beats.
// Optional: define STREAM_DEMUX_COUNT_EN to add count0/count1 saturating per-destination beat counters.

module stream_demux_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             valid,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign valid   = (count != '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && valid;

  // Storage, pointers and occupancy; reset clears entries so the head reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

module stream_demux #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef STREAM_DEMUX_COUNT_EN
  ,
  output logic [31:0]      count0,
  output logic [31:0]      count1
`endif
);
  logic full0;
  logic full1;
  logic push0;
  logic push1;

  // Ready looks only at the selected FIFO's registered fullness, never at the sinks.
  assign in_ready = in_sel ? !full1 : !full0;
  assign push0    = in_valid && in_ready && !in_sel;
  assign push1    = in_valid && in_ready &&  in_sel;

  stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst       (rst),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .full      (full0),
    .valid     (out0_valid),
    .head      (out0_data)
  );

  stream_demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .full      (full1),
    .valid     (out1_valid),
    .head      (out1_data)
  );

`ifdef STREAM_DEMUX_COUNT_EN
  // Per-destination accepted-beat counters, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count0 <= '0;
      count1 <= '0;
    end else begin
      if (push0 && (count0 != 32'hFFFF_FFFF)) count0 <= count0 + 32'd1;
      if (push1 && (count1 != 32'hFFFF_FFFF)) count1 <= count1 + 32'd1;
    end
  end
`endif
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
- 1-to-2 stream demultiplexer with valid/ready handshake. Each destination has its own FIFO.
- It is the routing counterpart of the datapath 2:1 mux. One producer stream (for example a writeback or memory-response path) is steered by a per-beat select bit to one of two consumers.
- Per-destination buffering means a stalled consumer blocks only beats addressed to it.
- Sits between the pipeline response source and two independent sinks.

Parameters:
- WIDTH, 32, data width of each beat.
- DEPTH, 2, entries per output FIFO. Must be a power of two and >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset. Asynchronous, active-high.
- in_valid  input  1  producer beat valid.
- in_ready  output  1  demux can accept the beat.
- in_sel  input  1  destination of the beat: 0 -> out0, 1 -> out1.
- in_data  input  WIDTH  beat payload.
- out0_valid  output  1  FIFO0 non-empty.
- out0_ready  input  1  consumer 0 accepts.
- out0_data  output  WIDTH  head of FIFO0.
- out1_valid  output  1  FIFO1 non-empty.
- out1_ready  input  1  consumer 1 accepts.
- out1_data  output  WIDTH  head of FIFO1.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - Both FIFOs empty; all pointers and occupancy counts = 0.
  - in_ready = 1; out0_valid = out1_valid = 0; out0_data = out1_data = 0.
- Transfers:
  - Input transfer = in_valid && in_ready at the clk edge. Output transfer k = outk_valid && outk_ready at the edge.
  - in_ready = !full[in_sel]. It depends only on registered occupancy and in_sel, never on outk_ready, so there is no combinational ready path through the block.
  - in_sel and in_data are sampled only on an input transfer. in_sel is don't-care while in_valid = 0.
- Push: an accepted beat is written at wr_ptr[in_sel]; wr_ptr increments; count[in_sel] increments unless a pop on the same FIFO coincides.
- Pop: on output transfer k, rd_ptr[k] increments and count[k] decrements unless a push to the same FIFO coincides.
- Latency: exactly 1 cycle from input transfer to outk_valid. There is no bypass, even when the FIFO is empty.
- Ordering: beats are strictly FIFO within each output. There is no ordering guarantee between out0 and out1.
- outk_data: registered head entry. Holds its value while outk_valid && !outk_ready. Undefined-but-stable (last value) when empty.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0. Occupancy counter is log2(DEPTH)+1 bits. full = (count == DEPTH); empty = (count == 0).
- Boundary conditions:
  - Full FIFO k with pop k in the same cycle: in_ready stays 0 for sel = k that cycle, and the slot frees for the next cycle.
  - Simultaneous push and pop on the same non-full, non-empty FIFO: count unchanged, both pointers advance.
  - Push and pop on the same FIFO while it is empty: the pop cannot occur because outk_valid = 0. The push lands and count = 1.
  - Push to FIFO0 while FIFO1 pops: independent, with no interaction.
  - Producer holding in_valid with in_sel pointing at a full FIFO: stalls. Dropping in_valid or changing in_sel before acceptance is permitted; no beat is recorded.
  - Reset mid-operation: all buffered beats are discarded immediately, outputs go invalid asynchronously, and no partial beat survives.

Optional Feature:
- Macro: STREAM_DEMUX_COUNT_EN.
- Defined:
  - Adds outputs count0 and count1 (32 bits each) = number of input transfers routed to out0 / out1 since reset.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
  - Counting occurs on the accepting edge.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then idle -> in_ready = 1, out0_valid = out1_valid = 0, both data = 0.
- Push 0xA5A5_0001 with sel = 0, out0_ready = 1 -> out0_valid = 1 with data 0xA5A5_0001 on the next cycle. out1_valid stays 0. Beat consumed one cycle later.
- out0_ready = 0; push 0x11, 0x22 (sel = 0), then attempt 0x33 (sel = 0) -> in_ready = 0 on the third beat. Push 0x44 (sel = 1) is accepted and appears on out1 while out0 is stalled. Raising out0_ready then yields 0x11, 0x22, 0x33 in order.
- FIFO0 full, out0_ready = 1 and in_valid with sel = 0 in the same cycle -> no accept that cycle, accept the following cycle. Count never exceeds DEPTH.
- Continuous alternating sel for 16 beats, both ready = 1 -> each output delivers 8 beats in order at one per two cycles with no stalls. Pointers wrap at least 4 times.
- Assert rst while both FIFOs hold 2 beats -> valids drop without waiting for a clock edge. After release, the first new push appears alone. With STREAM_DEMUX_COUNT_EN, count0/count1 read 0 after reset and 8/8 after the alternating test.
